// File: rtl/rom_download_ctrl.sv
// ROM download sequencer: buffers data_io bytes in a small FIFO and writes them to
// the two SDRAM ports with a toggle req/ack handshake, then releases the core reset.
`timescale 1ns/1ps
module rom_download_ctrl #(
  parameter logic [24:0] TILE_BASE   = 25'h20000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RST_HOLD    = 16,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_rst,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        dl_gate,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic [24:0] byte_count,
  output logic        overflow,
  output logic        timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {S_WAIT, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

  state_t          state_reg;
  logic            wr_reg;
  logic [24:0]     addr_mem [FIFO_DEPTH];
  logic [7:0]      data_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            busy_reg;
  logic            sel_reg;
  logic [TW-1:0]   wait_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg;

  logic            push_req, push, fifo_full, fifo_empty, issue;
  logic [24:0]     head_addr, sel_addr;
  logic [7:0]      head_data;
  logic            to_port2, acked, timed_out, done, enter_load, engine_park;
  logic [22:0]     issue_a;
  logic [1:0]      issue_ds;
  logic [15:0]     issue_d;

  // A strobe is a rising edge of ioctl_wr seen while the download is active.
  assign push_req   = ioctl_wr & ~wr_reg & ioctl_downl;
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = push_req & ~fifo_full;
  assign issue      = ~busy_reg & ~fifo_empty;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign to_port2  = (head_addr >= TILE_BASE);
  assign sel_addr  = to_port2 ? (head_addr - TILE_BASE) : head_addr;
  assign issue_a   = 23'(sel_addr >> 1);
  assign issue_ds  = {head_addr[0], ~head_addr[0]};
  assign issue_d   = {head_data, head_data};

  // Completion is req==ack on the port the outstanding byte went to.
  assign acked       = sel_reg ? (port2_req == port2_ack) : (port1_req == port1_ack);
  assign timed_out   = busy_reg & ~acked & (wait_cnt_reg == TW'(ACK_TIMEOUT - 1));
  assign done        = busy_reg & (acked | timed_out);
  assign enter_load  = ioctl_downl & ((state_reg == S_WAIT) | (state_reg == S_HOLD) |
                                      (state_reg == S_RUN));
  assign engine_park = (state_reg == S_RUN) | (state_reg == S_WAIT);

  always_ff @(posedge clk_sys) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= ioctl_addr;
      data_mem[wr_ptr_reg] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_reg     <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_reg <= ioctl_wr;
      if (push)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (issue) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, issue})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Issue engine: one byte in flight; outputs of a port are held until its next issue.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy_reg     <= 1'b0;
      sel_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      port1_req    <= port1_ack;
      port2_req    <= port2_ack;
      port1_we     <= 1'b0;
      port2_we     <= 1'b0;
      port1_a      <= '0;
      port1_ds     <= '0;
      port1_d      <= '0;
      port2_a      <= '0;
      port2_ds     <= '0;
      port2_d      <= '0;
    end else if (issue) begin
      busy_reg     <= 1'b1;
      sel_reg      <= to_port2;
      wait_cnt_reg <= '0;
      if (to_port2) begin
        port2_req <= ~port2_req;
        port2_a   <= issue_a;
        port2_ds  <= issue_ds;
        port2_d   <= issue_d;
        port2_we  <= 1'b1;
      end else begin
        port1_req <= ~port1_req;
        port1_a   <= issue_a;
        port1_ds  <= issue_ds;
        port1_d   <= issue_d;
        port1_we  <= 1'b1;
      end
    end else if (busy_reg) begin
      if (done) busy_reg <= 1'b0;
      else      wait_cnt_reg <= wait_cnt_reg + TW'(1);
    end else if (engine_park) begin
      port1_we <= 1'b0;
      port2_we <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= S_WAIT;
      hold_cnt_reg <= '0;
      core_reset   <= 1'b1;
      rom_loaded   <= 1'b0;
      dl_gate      <= 1'b0;
      byte_count   <= '0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (push)                  byte_count <= byte_count + 25'd1;
      if (push_req && fifo_full) overflow   <= 1'b1;
      if (timed_out)             timeout    <= 1'b1;

      if (enter_load) begin
        // A new download restarts the statistics; a byte accepted this cycle counts.
        state_reg  <= S_LOAD;
        byte_count <= 25'(push);
        overflow   <= 1'b0;
        timeout    <= 1'b0;
        rom_loaded <= 1'b0;
        dl_gate    <= 1'b1;
        core_reset <= 1'b1;
      end else begin
        case (state_reg)
          S_WAIT: begin
            core_reset <= 1'b1;
            dl_gate    <= 1'b0;
          end
          S_LOAD: begin
            if (!ioctl_downl) state_reg <= S_DRAIN;
          end
          S_DRAIN: begin
            if (fifo_empty && (!busy_reg || done)) begin
              state_reg    <= S_HOLD;
              hold_cnt_reg <= '0;
              dl_gate      <= 1'b0;
            end
          end
          S_HOLD: begin
            if (hold_cnt_reg == HW'(RST_HOLD - 1)) begin
              rom_loaded <= 1'b1;
              state_reg  <= S_RUN;
              core_reset <= user_rst;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + HW'(1);
            end
          end
          S_RUN: begin
            core_reset <= user_rst;
          end
          default: state_reg <= S_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: an SDRAM ack responder, a queue model of the
// expected port writes checked on every negedge, and hand-computed checks per scenario.
`timescale 1ns/1ps
module tb_rom_download_ctrl;

  localparam logic [24:0] TILE_BASE   = 25'h20000;
  localparam int          RST_HOLD    = 16;
  localparam int          ACK_TIMEOUT = 255;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_rst = 1'b0;
  logic        port1_req, port2_req;
  logic        port1_ack = 1'b0;
  logic        port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic        port1_we, port2_we;
  logic [15:0] port1_d, port2_d;
  logic        dl_gate, core_reset, rom_loaded, overflow, timeout;
  logic [24:0] byte_count;

  always #5 clk_sys = ~clk_sys;

  rom_download_ctrl #(
    .TILE_BASE(TILE_BASE), .FIFO_DEPTH(4), .RST_HOLD(RST_HOLD), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_rst(user_rst),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_we(port1_we), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_we(port2_we), .port2_d(port2_d),
    .dl_gate(dl_gate), .core_reset(core_reset), .rom_loaded(rom_loaded),
    .byte_count(byte_count), .overflow(overflow), .timeout(timeout)
  );

  // SDRAM responder: acks a pending request ack_lat+1 cycles after seeing it.
  bit ack_en = 1'b0;
  int ack_lat = 3;
  int late_ack_req = 0;
  int late_ack_seen = 0;
  int cnt1 = 0;
  int cnt2 = 0;

  always @(posedge clk_sys) begin
    if (late_ack_req != late_ack_seen) begin
      port1_ack     <= ~port1_ack;
      late_ack_seen <= late_ack_req;
    end else if (ack_en && port1_req != port1_ack) begin
      if (cnt1 >= ack_lat) begin port1_ack <= port1_req; cnt1 <= 0; end
      else cnt1 <= cnt1 + 1;
    end else begin
      cnt1 <= 0;
    end
    if (ack_en && port2_req != port2_ack) begin
      if (cnt2 >= ack_lat) begin port2_ack <= port2_req; cnt2 <= 0; end
      else cnt2 <= cnt2 + 1;
    end else begin
      cnt2 <= 0;
    end
  end

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_t;

  wr_t  q1[$];
  wr_t  q2[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  int   last_issue_cyc = 0;
  bit   in_reset = 1'b1;
  logic prev_req1 = 1'b0, prev_req2 = 1'b0, prev_ack1 = 1'b0, prev_ack2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Model: a byte below TILE_BASE lands in port1 at word addr/2, otherwise in port2
  // at word (addr-TILE_BASE)/2; an odd byte address selects the high lane.
  task automatic expect_write(input logic [24:0] addr, input logic [7:0] data);
    wr_t w;
    logic [24:0] off;
    off  = (addr < TILE_BASE) ? addr : addr - TILE_BASE;
    w.a  = 23'(off / 2);
    w.ds = (addr % 2 == 1) ? 2'b10 : 2'b01;
    w.d  = 16'(data) * 16'h0101;
    if (addr < TILE_BASE) q1.push_back(w);
    else q2.push_back(w);
  endtask

  task automatic cycle_check();
    wr_t w;
    cyc++;
    if (!in_reset) begin
      if (port1_req !== prev_req1) begin
        last_issue_cyc = cyc;
        $display("port1 write a=%h ds=%b d=%h we=%b", port1_a, port1_ds, port1_d, port1_we);
        if (q1.size() == 0) begin
          checks++;
          $display("FAIL p1_unexpected_req: got toggle, required none");
        end else begin
          w = q1.pop_front();
          check("p1_a", 32'(port1_a), 32'(w.a));
          check("p1_ds", 32'(port1_ds), 32'(w.ds));
          check("p1_d", 32'(port1_d), 32'(w.d));
          check("p1_we", 32'(port1_we), 1);
        end
      end
      if (port2_req !== prev_req2) begin
        last_issue_cyc = cyc;
        $display("port2 write a=%h ds=%b d=%h we=%b", port2_a, port2_ds, port2_d, port2_we);
        if (q2.size() == 0) begin
          checks++;
          $display("FAIL p2_unexpected_req: got toggle, required none");
        end else begin
          w = q2.pop_front();
          check("p2_a", 32'(port2_a), 32'(w.a));
          check("p2_ds", 32'(port2_ds), 32'(w.ds));
          check("p2_d", 32'(port2_d), 32'(w.d));
          check("p2_we", 32'(port2_we), 1);
        end
      end
      if (dl_gate) check("gate_holds_reset", 32'(core_reset), 1);
    end
    if (port1_ack !== prev_ack1 || port2_ack !== prev_ack2) last_ack_cyc = cyc;
    prev_req1 = port1_req;
    prev_req2 = port2_req;
    prev_ack1 = port1_ack;
    prev_ack2 = port2_ack;
  endtask

  task automatic tick();
    @(negedge clk_sys);
    cycle_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data, input bit accept);
    if (accept) expect_write(addr, data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic wait_loaded(input string name);
    int n;
    n = 0;
    while (rom_loaded !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(rom_loaded), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saved_req;

    // Reset state
    ticks(3);
    check("rst_core_reset", 32'(core_reset), 1);
    check("rst_rom_loaded", 32'(rom_loaded), 0);
    check("rst_dl_gate", 32'(dl_gate), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_p1_we", 32'(port1_we), 0);
    check("rst_p2_we", 32'(port2_we), 0);
    check("rst_p1_req", 32'(port1_req), 32'(port1_ack));
    reset = 1'b0;
    tick();
    in_reset = 1'b0;
    ack_en = 1'b1;

    // Four bytes to port1, then the hold period
    ioctl_downl = 1'b1;
    ticks(2);
    check("load_dl_gate", 32'(dl_gate), 1);
    for (int i = 0; i < 4; i++) strobe(25'(i), 8'(i), 1'b1);
    ioctl_downl = 1'b0;
    wait_loaded("t1_loaded");
    // The DUT samples the final ack one edge after it changes; the hold runs from there.
    check("t1_hold_cycles", 32'(cyc - last_ack_cyc), RST_HOLD + 1);
    check("t1_byte_count", 32'(byte_count), 4);
    check("t1_last_a", 32'(port1_a), 1);
    check("t1_last_ds", 32'(port1_ds), 32'b10);
    check("t1_last_d", 32'(port1_d), 32'h0303);
    check("t1_core_reset", 32'(core_reset), 0);
    check("t1_dl_gate", 32'(dl_gate), 0);
    check("t1_q1_empty", 32'(q1.size()), 0);

    // One tile byte to port2
    saved_req = port1_req;
    ioctl_downl = 1'b1;
    ticks(2);
    strobe(25'h20003, 8'hAB, 1'b1);
    ioctl_downl = 1'b0;
    wait_loaded("t2_loaded");
    check("t2_p2_a", 32'(port2_a), 1);
    check("t2_p2_ds", 32'(port2_ds), 32'b10);
    check("t2_p2_d", 32'(port2_d), 32'hABAB);
    check("t2_p1_req_same", 32'(port1_req), 32'(saved_req));
    check("t2_byte_count", 32'(byte_count), 1);
    check("t2_q2_empty", 32'(q2.size()), 0);

    // Ack withheld: one in flight plus four buffered, the sixth byte is dropped
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    ticks(2);
    strobe(25'h00010, 8'h31, 1'b1);
    strobe(25'h20011, 8'h32, 1'b1);
    strobe(25'h00012, 8'h33, 1'b1);
    strobe(25'h20013, 8'h34, 1'b1);
    strobe(25'h00014, 8'h35, 1'b1);
    check("t3_no_overflow_yet", 32'(overflow), 0);
    strobe(25'h00015, 8'h36, 1'b0);
    check("t3_overflow", 32'(overflow), 1);
    check("t3_byte_count", 32'(byte_count), 5);
    ack_en = 1'b1;
    ioctl_downl = 1'b0;
    wait_loaded("t3_loaded");
    check("t3_q1_empty", 32'(q1.size()), 0);
    check("t3_q2_empty", 32'(q2.size()), 0);
    check("t3_overflow_sticky", 32'(overflow), 1);

    // Ack never returns: timeout, then the next entry issues
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    ticks(2);
    strobe(25'h00040, 8'h51, 1'b1);
    strobe(25'h00041, 8'h52, 1'b1);
    begin
      int t0;
      t0 = last_issue_cyc;
      while (cyc < t0 + 200) tick();
      check("t4_no_timeout_early", 32'(timeout), 0);
      while (cyc < t0 + 260) tick();
      check("t4_timeout", 32'(timeout), 1);
    end
    ioctl_downl = 1'b0;
    wait_loaded("t4_loaded");
    check("t4_q1_empty", 32'(q1.size()), 0);
    check("t4_timeout_sticky", 32'(timeout), 1);
    ack_en = 1'b1;

    // user_rst pass-through in S_RUN, then a restarted empty download
    tick();
    check("t5_core_reset_idle", 32'(core_reset), 0);
    user_rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t5_core_reset_follow", 32'(core_reset), (k <= 3) ? 1 : 0);
      if (k == 3) user_rst = 1'b0;
    end
    ioctl_downl = 1'b1;
    tick();
    check("t5_dl_gate", 32'(dl_gate), 1);
    check("t5_rom_loaded", 32'(rom_loaded), 0);
    check("t5_byte_count", 32'(byte_count), 0);
    check("t5_core_reset", 32'(core_reset), 1);
    ioctl_downl = 1'b0;
    wait_loaded("t5_empty_loaded");
    check("t5_empty_count", 32'(byte_count), 0);

    // Reset while a request is outstanding, then a late ack
    ack_en = 1'b0;
    ioctl_downl = 1'b1;
    ticks(2);
    strobe(25'h00080, 8'h77, 1'b1);
    check("t6_outstanding", 32'(port1_req ^ port1_ack), 1);
    in_reset = 1'b1;
    reset = 1'b1;
    ioctl_downl = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
    in_reset = 1'b0;
    check("t6_core_reset", 32'(core_reset), 1);
    check("t6_dl_gate", 32'(dl_gate), 0);
    check("t6_rom_loaded", 32'(rom_loaded), 0);
    check("t6_byte_count", 32'(byte_count), 0);
    check("t6_p1_we", 32'(port1_we), 0);
    check("t6_req_resync", 32'(port1_req), 32'(port1_ack));
    saved_req = port1_req;
    late_ack_req++;
    ticks(10);
    check("t6_no_new_req", 32'(port1_req), 32'(saved_req));
    check("t6_we_after_ack", 32'(port1_we), 0);
    check("t6_still_wait_rst", 32'(core_reset), 1);
    check("t6_still_wait_gate", 32'(dl_gate), 0);
    check("final_q1_empty", 32'(q1.size()), 0);
    check("final_q2_empty", 32'(q2.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
